// File: rtl/control_unit_mc_if.sv
// Shared types for the K&S control unit plus the controller/datapath bus interface.
// Optional retired-instruction counter port is present only when KS_CU_PERF_EN is defined.

package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;

  // Control strobes driven by the control unit towards the datapath and RAM.
  typedef struct packed {
    logic mem_req;
    logic ram_write_enable;
    logic addr_sel;
    logic c_sel;
    logic ir_enable;
    logic pc_enable;
    logic branch;
    logic write_reg_enable;
    logic flags_reg_enable;
    logic halt;
    logic mem_error;
  } cu_ctrl_t;

endpackage

interface control_unit_mc_if
  import k_and_s_pkg::*;
#(
  parameter int unsigned OP_W         = 2,
  parameter int unsigned RETIRE_CNT_W = 16
);

  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic                    mem_ready;

  logic                    mem_req;
  logic                    ram_write_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic                    ir_enable;
  logic                    pc_enable;
  logic                    branch;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic [OP_W-1:0]         operation;
  logic                    halt;
  logic                    mem_error;

`ifdef KS_CU_PERF_EN
  logic [RETIRE_CNT_W-1:0] instr_retired;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow, mem_ready,
    output mem_req, ram_write_enable, addr_sel, c_sel, ir_enable, pc_enable, branch,
           write_reg_enable, flags_reg_enable, operation, halt, mem_error, instr_retired
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow, mem_ready,
    input  mem_req, ram_write_enable, addr_sel, c_sel, ir_enable, pc_enable, branch,
           write_reg_enable, flags_reg_enable, operation, halt, mem_error, instr_retired
  );
`else
  localparam int unsigned unused_retire_w = RETIRE_CNT_W;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow, mem_ready,
    output mem_req, ram_write_enable, addr_sel, c_sel, ir_enable, pc_enable, branch,
           write_reg_enable, flags_reg_enable, operation, halt, mem_error
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow, mem_ready,
    input  mem_req, ram_write_enable, addr_sel, c_sel, ir_enable, pc_enable, branch,
           write_reg_enable, flags_reg_enable, operation, halt, mem_error
  );
`endif

endinterface

// File: rtl/control_unit_mc.sv
// Multicycle K&S control unit: fetch/decode/execute sequencing with a variable-latency
// memory handshake, wait-state timeout and sticky HALTED/ERROR stop.
// Optional feature macro: KS_CU_PERF_EN adds a saturating retired-instruction counter.

module control_unit_mc
  import k_and_s_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned OP_W         = 2,
  parameter int unsigned RETIRE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  control_unit_mc_if.master      bus_io
);

  // Counter only needs to reach MEM_WAIT_MAX-1 before the timeout fires.
  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_LATCH_IR = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MEM_LD   = 4'd4,
    S_LD_WB    = 4'd5,
    S_MEM_ST   = 4'd6,
    S_BRANCH   = 4'd7,
    S_NEXT     = 4'd8,
    S_HALTED   = 4'd9,
    S_ERROR    = 4'd10
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OP_W-1:0]   operation_q;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  cu_ctrl_t          ctrl_q;
  logic              timeout_c;
  logic              unused_flags;

  assign unused_flags = bus_io.unsigned_overflow ^ bus_io.signed_overflow;

  // Moore output decode for a given state.
  function automatic cu_ctrl_t ctrl_of(input state_e s);
    cu_ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.addr_sel = 1'b1; end
      S_LATCH_IR: begin c.ir_enable = 1'b1; c.addr_sel = 1'b1; end
      S_EXEC:     begin c.write_reg_enable = 1'b1; c.flags_reg_enable = 1'b1; end
      S_MEM_LD:   begin c.mem_req = 1'b1; c.c_sel = 1'b1; end
      S_LD_WB:    begin c.c_sel = 1'b1; c.write_reg_enable = 1'b1; end
      S_MEM_ST:   begin c.mem_req = 1'b1; c.ram_write_enable = 1'b1; end
      S_BRANCH:   begin c.pc_enable = 1'b1; c.branch = 1'b1; end
      S_NEXT:     begin c.pc_enable = 1'b1; end
      S_HALTED:   begin c.halt = 1'b1; end
      S_ERROR:    begin c.halt = 1'b1; c.mem_error = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // ALU operation encoding for the decoded instruction.
  function automatic logic [OP_W-1:0] op_of(input decoded_instruction_type i);
    case (i)
      I_ADD:   return OP_W'(2'b01);
      I_SUB:   return OP_W'(2'b10);
      I_AND:   return OP_W'(2'b11);
      default: return OP_W'(2'b00);
    endcase
  endfunction

  assign timeout_c = (MEM_WAIT_MAX != 0) &&
                     (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX - 1)) && !bus_io.mem_ready;

  // Next-state, opcode latch and memory wait counter.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = '0;
    case (state_q)
      S_FETCH, S_MEM_LD, S_MEM_ST: begin
        if (bus_io.mem_ready) begin
          case (state_q)
            S_FETCH:  state_d = S_LATCH_IR;
            S_MEM_LD: state_d = S_LD_WB;
            default:  state_d = S_NEXT;
          endcase
        end else if (timeout_c) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_LATCH_IR: state_d = S_DECODE;
      S_DECODE: begin
        op_d = op_of(bus_io.decoded_instruction);
        case (bus_io.decoded_instruction)
          I_LOAD:                      state_d = S_MEM_LD;
          I_STORE:                     state_d = S_MEM_ST;
          I_MOVE, I_ADD, I_SUB,
          I_AND, I_OR:                 state_d = S_EXEC;
          I_BRANCH:                    state_d = S_BRANCH;
          I_BZERO:  state_d = bus_io.zero_op  ? S_BRANCH : S_NEXT;
          I_BNZERO: state_d = !bus_io.zero_op ? S_BRANCH : S_NEXT;
          I_BNEG:   state_d = bus_io.neg_op   ? S_BRANCH : S_NEXT;
          I_BNNEG:  state_d = !bus_io.neg_op  ? S_BRANCH : S_NEXT;
          I_HALT:                      state_d = S_HALTED;
          default:                     state_d = S_NEXT;
        endcase
      end
      S_EXEC:   state_d = S_NEXT;
      S_LD_WB:  state_d = S_NEXT;
      S_BRANCH: state_d = S_FETCH;
      S_NEXT:   state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      wait_cnt_q  <= '0;
      ctrl_q      <= ctrl_of(S_FETCH);
      operation_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_cnt_q  <= wait_cnt_d;
      ctrl_q      <= ctrl_of(state_d);
      operation_q <= (state_d == S_EXEC) ? op_d : '0;
    end
  end

  assign bus_io.mem_req          = ctrl_q.mem_req;
  assign bus_io.ram_write_enable = ctrl_q.ram_write_enable;
  assign bus_io.addr_sel         = ctrl_q.addr_sel;
  assign bus_io.c_sel            = ctrl_q.c_sel;
  assign bus_io.ir_enable        = ctrl_q.ir_enable;
  assign bus_io.pc_enable        = ctrl_q.pc_enable;
  assign bus_io.branch           = ctrl_q.branch;
  assign bus_io.write_reg_enable = ctrl_q.write_reg_enable;
  assign bus_io.flags_reg_enable = ctrl_q.flags_reg_enable;
  assign bus_io.halt             = ctrl_q.halt;
  assign bus_io.mem_error        = ctrl_q.mem_error;
  assign bus_io.operation        = operation_q;

`ifdef KS_CU_PERF_EN
  logic [RETIRE_CNT_W-1:0] retired_q;

  // Saturating count of cycles that advance the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (ctrl_q.pc_enable && (retired_q != '1)) begin
      retired_q <= retired_q + RETIRE_CNT_W'(1);
    end
  end

  assign bus_io.instr_retired = retired_q;
`else
  localparam int unsigned unused_retire_w = RETIRE_CNT_W;
`endif

endmodule
